// File: rtl/fetch_queue_pkg.sv
// fetch_pkg: shared types and defaults for the fetch queue slice.
//   fq_state_t    - queue control state (RUN / SQUASH)
//   fetch_entry_t - one buffered fetch beat (pc, instr) at the default word width
//   FQ_DEPTH_DEFAULT, FQ_D_WIDTH_DEFAULT - default sizing
package fetch_pkg;

    localparam int unsigned FQ_DEPTH_DEFAULT   = 4;
    localparam int unsigned FQ_D_WIDTH_DEFAULT = 32;

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } fq_state_t;

    typedef struct packed {
        logic [FQ_D_WIDTH_DEFAULT-1:0] pc;
        logic [FQ_D_WIDTH_DEFAULT-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_storage.sv
// fq_storage: DEPTH x W register array, one synchronous write port and one
// asynchronous read port. Contents are not reset.
//   CLK   - clock, rising edge
//   we    - write enable
//   waddr - write index
//   wdata - write data
//   raddr - read index
//   rdata - read data (combinational from raddr)
module fq_storage #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: buffers PC/instruction pairs from instruction memory and hands
// them to decode with a valid/ready handshake. Back-pressures the PC register
// through FetchReady and squashes in-flight fetch responses after a Flush.
//   CLK, rst                          - clock / async active-high reset
//   FetchValid, FetchPC, FetchInstr   - fetch response beat
//   FetchReady                        - queue can accept a beat (PC holds when low)
//   Flush                             - redirect: empty queue, squash MEM_LAT responses
//   DecValid, DecPC, DecInstr         - head entry to decode (zero when empty)
//   DecReady                          - decode takes the head this cycle
//   Count                             - current occupancy
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned D_WIDTH = FQ_D_WIDTH_DEFAULT,
    parameter int unsigned DEPTH   = FQ_DEPTH_DEFAULT,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic                       CLK,
    input  logic                       rst,
    input  logic                       FetchValid,
    input  logic [D_WIDTH-1:0]         FetchPC,
    input  logic [D_WIDTH-1:0]         FetchInstr,
    output logic                       FetchReady,
    input  logic                       Flush,
    output logic                       DecValid,
    output logic [D_WIDTH-1:0]         DecPC,
    output logic [D_WIDTH-1:0]         DecInstr,
    input  logic                       DecReady,
    output logic [$clog2(DEPTH):0]     Count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fq_state_t         state, state_d;
    logic [1:0]        sq_cnt;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count_q;
    logic              push, pop;
    logic [2*D_WIDTH-1:0] rdata;

    assign push = (state == RUN) && FetchValid && FetchReady && !Flush;
    assign pop  = DecValid && DecReady && !Flush;

    fq_storage #(
        .DEPTH (DEPTH),
        .W     (2 * D_WIDTH),
        .AW    (AW)
    ) u_storage (
        .CLK   (CLK),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({FetchPC, FetchInstr}),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    // State register
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic: Flush always wins; SQUASH exits on the 1 -> 0 count edge
    always_comb begin
        state_d = state;
        if (Flush) begin
            state_d = (MEM_LAT > 0) ? SQUASH : RUN;
        end else if (state == SQUASH && sq_cnt <= 2'd1) begin
            state_d = RUN;
        end
    end

    // Output logic: FetchReady depends only on registered state/Count
    always_comb begin
        DecValid   = (count_q != '0);
        FetchReady = (state == SQUASH) ? 1'b1 : (count_q < CW'(DEPTH));
        DecPC      = '0;
        DecInstr   = '0;
        if (DecValid) begin
            DecPC    = rdata[2*D_WIDTH-1:D_WIDTH];
            DecInstr = rdata[D_WIDTH-1:0];
        end
    end

    assign Count = count_q;

    // Squash counter
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            sq_cnt <= '0;
        end else if (Flush) begin
            sq_cnt <= 2'(MEM_LAT);
        end else if (state == SQUASH && sq_cnt != '0) begin
            sq_cnt <= sq_cnt - 2'd1;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (Flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    logic        CLK = 1'b0;
    logic        rst;
    logic        FetchValid;
    logic [31:0] FetchPC;
    logic [31:0] FetchInstr;
    logic        FetchReady;
    logic        Flush;
    logic        DecValid;
    logic [31:0] DecPC;
    logic [31:0] DecInstr;
    logic        DecReady;
    logic [2:0]  Count;

    int checks   = 0;
    int failures = 0;

    fetch_queue #(
        .D_WIDTH (32),
        .DEPTH   (4),
        .MEM_LAT (1)
    ) dut (
        .CLK        (CLK),
        .rst        (rst),
        .FetchValid (FetchValid),
        .FetchPC    (FetchPC),
        .FetchInstr (FetchInstr),
        .FetchReady (FetchReady),
        .Flush      (Flush),
        .DecValid   (DecValid),
        .DecPC      (DecPC),
        .DecInstr   (DecInstr),
        .DecReady   (DecReady),
        .Count      (Count)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hC0DE_0000;
    endfunction

    // One clock: inputs are held across the edge, outputs settle 1 time unit later
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        FetchValid = v;
        FetchPC    = pc;
        FetchInstr = instr_of(pc);
        DecReady   = rdy;
        Flush      = fl;
    endtask

    task automatic test_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        #12;
        rst = 1'b0;
        step();
        step();
        checks++;
        if (DecValid !== 1'b0) begin failures++; $display("FAIL reset_decvalid got=%b exp=0", DecValid); end
        checks++;
        if (FetchReady !== 1'b1) begin failures++; $display("FAIL reset_fetchready got=%b exp=1", FetchReady); end
        checks++;
        if (Count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", Count); end
        checks++;
        if (DecPC !== 32'h0 || DecInstr !== 32'h0) begin
            failures++; $display("FAIL reset_decdata got pc=%h instr=%h exp 0/0", DecPC, DecInstr);
        end
    endtask

    task automatic test_fill_full();
        logic [31:0] pcs [4];
        pcs = '{32'h00, 32'h04, 32'h08, 32'h0C};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, pcs[i], 1'b0, 1'b0);
            step();
            if (i == 0) begin
                checks++;
                if (DecValid !== 1'b1 || DecPC !== 32'h00) begin
                    failures++; $display("FAIL first_push_latency got valid=%b pc=%h exp 1/00000000", DecValid, DecPC);
                end
            end
        end
        checks++;
        if (Count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", Count); end
        checks++;
        if (FetchReady !== 1'b0) begin failures++; $display("FAIL full_fetchready got=%b exp=0", FetchReady); end
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        step();
        checks++;
        if (Count !== 3'd4) begin failures++; $display("FAIL full_fifth_count got=%0d exp=4", Count); end
        checks++;
        if (DecPC !== 32'h00 || DecInstr !== instr_of(32'h00)) begin
            failures++; $display("FAIL full_head got pc=%h instr=%h exp pc=00000000", DecPC, DecInstr);
        end
    endtask

    task automatic test_drain_wrap();
        logic [31:0] exp_pc [6];
        logic        fv     [6];
        logic [31:0] fpc    [6];
        exp_pc = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14};
        // cycle 0 is still full, so 0x10 offered there is refused and re-offered
        fv     = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        fpc    = '{32'h10, 32'h10, 32'h14, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 6; i++) begin
            drive(fv[i], fpc[i], 1'b1, 1'b0);
            checks++;
            if (DecValid !== 1'b1 || DecPC !== exp_pc[i] || DecInstr !== instr_of(exp_pc[i])) begin
                failures++;
                $display("FAIL drain_order[%0d] got valid=%b pc=%h instr=%h exp pc=%h", i, DecValid, DecPC, DecInstr, exp_pc[i]);
            end
            step();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (Count !== 3'd0 || DecValid !== 1'b0 || DecPC !== 32'h0) begin
            failures++; $display("FAIL drain_empty got count=%0d valid=%b pc=%h exp 0/0/0", Count, DecValid, DecPC);
        end
    endtask

    task automatic test_push_pop();
        drive(1'b1, 32'h18, 1'b0, 1'b0); step();
        drive(1'b1, 32'h1C, 1'b0, 1'b0); step();
        checks++;
        if (Count !== 3'd2 || DecPC !== 32'h18) begin
            failures++; $display("FAIL pp_setup got count=%0d pc=%h exp 2/00000018", Count, DecPC);
        end
        drive(1'b1, 32'h20, 1'b1, 1'b0); step();
        checks++;
        if (Count !== 3'd2 || DecPC !== 32'h1C) begin
            failures++; $display("FAIL pp_simul got count=%0d pc=%h exp 2/0000001c", Count, DecPC);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0); step();
        checks++;
        if (Count !== 3'd1 || DecPC !== 32'h20 || DecInstr !== instr_of(32'h20)) begin
            failures++; $display("FAIL pp_tail got count=%0d pc=%h instr=%h exp 1/00000020", Count, DecPC, DecInstr);
        end
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (Count !== 3'd0) begin failures++; $display("FAIL pp_empty got count=%0d exp=0", Count); end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h30, 1'b0, 1'b0); step();
        drive(1'b1, 32'h34, 1'b0, 1'b0); step();
        drive(1'b1, 32'h38, 1'b0, 1'b0); step();
        checks++;
        if (Count !== 3'd3) begin failures++; $display("FAIL flush_setup got count=%0d exp=3", Count); end
        drive(1'b0, 32'h0, 1'b1, 1'b1); step();
        checks++;
        if (Count !== 3'd0 || DecValid !== 1'b0 || FetchReady !== 1'b1) begin
            failures++; $display("FAIL flush_clear got count=%0d valid=%b ready=%b exp 0/0/1", Count, DecValid, FetchReady);
        end
        drive(1'b1, 32'h40, 1'b0, 1'b0); step();
        checks++;
        if (Count !== 3'd0 || DecValid !== 1'b0) begin
            failures++; $display("FAIL flush_squash got count=%0d valid=%b exp 0/0", Count, DecValid);
        end
        drive(1'b1, 32'h80, 1'b0, 1'b0); step();
        checks++;
        if (Count !== 3'd1 || DecPC !== 32'h80 || DecInstr !== instr_of(32'h80)) begin
            failures++; $display("FAIL flush_resume got count=%0d pc=%h instr=%h exp 1/00000080", Count, DecPC, DecInstr);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0); step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        drive(1'b1, 32'h50, 1'b0, 1'b0); step();
        drive(1'b1, 32'h54, 1'b0, 1'b0); step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (Count !== 3'd2) begin failures++; $display("FAIL arst_setup got count=%0d exp=2", Count); end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (DecValid !== 1'b0 || Count !== 3'd0 || DecPC !== 32'h0) begin
            failures++; $display("FAIL arst_immediate got valid=%b count=%0d pc=%h exp 0/0/0", DecValid, Count, DecPC);
        end
        #10;
        rst = 1'b0;
        step();
        checks++;
        if (FetchReady !== 1'b1 || Count !== 3'd0) begin
            failures++; $display("FAIL arst_after got ready=%b count=%0d exp 1/0", FetchReady, Count);
        end
    endtask

    initial begin
        test_reset();
        test_fill_full();
        test_drain_wrap();
        test_push_pop();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
